// File: rtl/spi_shift_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine_pkg
// Description : Shared types and constants for the SPI shift engine.
//               - transfer state encoding (IDLE, LEAD, SHIFT, TRAIL, DONE)
//               - SPI mode constants, encoded as {cpol, cpha}
//               - default data and divider widths
// Revision    : 1.0 - initial release
// ============================================================================
package spi_shift_engine_pkg;

    localparam int c_DATA_W_DEFAULT = 8;
    localparam int c_DIV_W_DEFAULT  = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_TRAIL = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // SPI modes as {cpol, cpha}
    localparam logic [1:0] c_MODE0 = 2'b00;
    localparam logic [1:0] c_MODE1 = 2'b01;
    localparam logic [1:0] c_MODE2 = 2'b10;
    localparam logic [1:0] c_MODE3 = 2'b11;

endpackage : spi_shift_engine_pkg
`default_nettype wire

// File: rtl/spi_shift_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine_if
// Description : Controller-side command/status bus of the SPI shift engine.
//               master : the controller (issues start + settings, sees status)
//               slave  : the shift engine
//   i_start      request a transfer (accepted only while idle)
//   i_tx_data    word to transmit
//   i_clk_div    SCLK half-period minus one, in clk cycles
//   i_cpol/i_cpha/i_lsb_first  transfer mode
//   o_busy       transfer in progress
//   o_done       one-cycle end-of-transfer pulse
//   o_rx_data    last received word
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_shift_engine_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
);
    logic              i_start;
    logic [DATA_W-1:0] i_tx_data;
    logic [DIV_W-1:0]  i_clk_div;
    logic              i_cpol;
    logic              i_cpha;
    logic              i_lsb_first;
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_rx_data;

    modport master (
        output i_start, i_tx_data, i_clk_div, i_cpol, i_cpha, i_lsb_first,
        input  o_busy, o_done, o_rx_data
    );

    modport slave (
        input  i_start, i_tx_data, i_clk_div, i_cpol, i_cpha, i_lsb_first,
        output o_busy, o_done, o_rx_data
    );

endinterface : spi_shift_engine_if
`default_nettype wire

// File: rtl/spi_shift_engine_half_period_timer.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine_half_period_timer
// Description : Loadable DIV_W-bit down-counter. While enabled it emits a
//               one-cycle o_tick every (i_reload_val + 1) cycles, reloading
//               itself on each tick. i_load restarts the count cleanly.
//   clk, RST      clock and synchronous active-high reset
//   i_load        load i_reload_val (takes priority over i_en, no tick)
//   i_en          count enable
//   i_reload_val  half-period minus one
//   o_tick        last cycle of the current half-period
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_engine_half_period_timer #(
    parameter int DIV_W = 8
) (
    input  wire logic             clk,
    input  wire logic             RST,
    input  wire logic             i_load,
    input  wire logic             i_en,
    input  wire logic [DIV_W-1:0] i_reload_val,
    output logic                  o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_zero;

    assign w_zero = (r_cnt == '0);
    assign o_tick = i_en && !i_load && w_zero;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_reload_val;
        end else if (i_en) begin
            if (w_zero) begin
                r_cnt <= i_reload_val;
            end else begin
                r_cnt <= r_cnt - DIV_W'(1);
            end
        end
    end

endmodule : spi_shift_engine_half_period_timer
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine
// Description : SPI master serializer/deserializer. Accepts one word plus mode
//               and divider settings, runs a full SPI transfer on
//               o_sclk/o_mosi/o_cs_n/i_miso and returns the received word with
//               a one-cycle done pulse. All outputs are registered.
//   clk, RST   clock and synchronous active-high reset
//   bus        controller command/status bus (slave modport)
//   i_miso     serial data in
//   o_mosi     serial data out
//   o_sclk     SPI clock
//   o_cs_n     active-low chip select
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int DIV_W  = c_DIV_W_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          RST,
    spi_shift_engine_if.slave  bus,
    input  wire logic          i_miso,
    output logic               o_mosi,
    output logic               o_sclk,
    output logic               o_cs_n
);

    localparam logic [2:0] c_ST_IDLE  = S_IDLE;
    localparam logic [2:0] c_ST_LEAD  = S_LEAD;
    localparam logic [2:0] c_ST_SHIFT = S_SHIFT;
    localparam logic [2:0] c_ST_TRAIL = S_TRAIL;
    localparam logic [2:0] c_ST_DONE  = S_DONE;

    localparam int                c_EDGE_W    = $clog2(2 * DATA_W + 1);
    localparam logic [c_EDGE_W-1:0] c_LAST_EDGE = c_EDGE_W'(2 * DATA_W);

    logic [2:0]          r_state;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_rx_data;
    logic [DIV_W-1:0]    r_clk_div;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_lsb_first;
    logic                r_setup;
    logic [c_EDGE_W-1:0] r_edge_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_mosi;
    logic                r_sclk;
    logic                r_cs_n;

    logic                w_tick;
    logic                w_tmr_en;
    logic [c_EDGE_W-1:0] w_edge_num;
    logic                w_leading;
    logic                w_last_edge;
    logic                w_sample;
    logic                w_drive;
    logic [DATA_W-1:0]   w_tx_shifted;
    logic                w_tx_head;
    logic                w_next_head;
    logic                w_start_head;
    logic [DATA_W-1:0]   w_rx_shifted;

    // The first LEAD cycle only loads the timer from the freshly latched
    // divider; the timer then runs uninterrupted through LEAD, SHIFT and
    // TRAIL, reloading itself at every half-period boundary.
    assign w_tmr_en = !r_setup && ((r_state == c_ST_LEAD) ||
                                   (r_state == c_ST_SHIFT) ||
                                   (r_state == c_ST_TRAIL));

    spi_shift_engine_half_period_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk          (clk),
        .RST          (RST),
        .i_load       (r_setup),
        .i_en         (w_tmr_en),
        .i_reload_val (r_clk_div),
        .o_tick       (w_tick)
    );

    always_comb begin
        w_edge_num   = r_edge_cnt + c_EDGE_W'(1);
        // Edge numbers are 1-based: odd = leading edge, even = trailing edge.
        w_leading    = w_edge_num[0];
        w_last_edge  = (w_edge_num == c_LAST_EDGE);
        // CPHA=0: sample leading, drive trailing (never after the final edge).
        // CPHA=1: drive leading, sample trailing.
        w_sample     = r_cpha ? !w_leading : w_leading;
        w_drive      = r_cpha ? w_leading : (!w_leading && !w_last_edge);
        w_tx_shifted = r_lsb_first ? (r_tx >> 1) : (r_tx << 1);
        w_tx_head    = r_lsb_first ? r_tx[0] : r_tx[DATA_W-1];
        w_next_head  = r_lsb_first ? r_tx[1] : r_tx[DATA_W-2];
        w_start_head = bus.i_lsb_first ? bus.i_tx_data[0] : bus.i_tx_data[DATA_W-1];
        // Received bits assemble in transmit order.
        w_rx_shifted = r_lsb_first ? {i_miso, r_rx[DATA_W-1:1]}
                                   : {r_rx[DATA_W-2:0], i_miso};
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state     <= c_ST_IDLE;
            r_tx        <= '0;
            r_rx        <= '0;
            r_rx_data   <= '0;
            r_clk_div   <= '0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_lsb_first <= 1'b0;
            r_setup     <= 1'b0;
            r_edge_cnt  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mosi      <= 1'b0;
            r_sclk      <= 1'b0;
            r_cs_n      <= 1'b1;
        end else begin
            r_done  <= 1'b0;
            r_setup <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_sclk <= bus.i_cpol;
                    r_cs_n <= 1'b1;
                    if (bus.i_start) begin
                        r_tx        <= bus.i_tx_data;
                        r_clk_div   <= bus.i_clk_div;
                        r_cpol      <= bus.i_cpol;
                        r_cpha      <= bus.i_cpha;
                        r_lsb_first <= bus.i_lsb_first;
                        r_mosi      <= w_start_head;
                        r_rx        <= '0;
                        r_edge_cnt  <= '0;
                        r_cs_n      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_setup     <= 1'b1;
                        r_state     <= c_ST_LEAD;
                    end
                end
                c_ST_LEAD: begin
                    if (w_tick) begin
                        r_state <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_tick) begin
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= w_edge_num;
                        if (w_sample) begin
                            r_rx <= w_rx_shifted;
                        end
                        if (w_drive) begin
                            r_tx   <= w_tx_shifted;
                            // CPHA=1 re-presents the current head (the first
                            // leading edge repeats the bit shown in LEAD);
                            // CPHA=0 advances to the following bit.
                            r_mosi <= r_cpha ? w_tx_head : w_next_head;
                        end
                        if (w_last_edge) begin
                            r_state <= c_ST_TRAIL;
                        end
                    end
                end
                c_ST_TRAIL: begin
                    if (w_tick) begin
                        r_busy    <= 1'b0;
                        r_cs_n    <= 1'b1;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx;
                        r_state   <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_sclk  <= r_cpol;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
    assign bus.o_rx_data = r_rx_data;
    assign o_mosi        = r_mosi;
    assign o_sclk        = r_sclk;
    assign o_cs_n        = r_cs_n;

endmodule : spi_shift_engine
`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_shift_engine
// Description : Self-checking bench for spi_shift_engine. A behavioural SPI
//               slave watches o_sclk/o_cs_n, answers on i_miso with a chosen
//               word, and records the o_mosi bit it would latch on each of
//               its sampling edges. Expected values come from the SPI rules:
//               bit order, edge counts, half-period and transfer latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_shift_engine;
    import spi_shift_engine_pkg::*;

    localparam int DW  = 8;
    localparam int DVW = 8;

    logic clk = 1'b0;
    logic RST;
    logic i_miso;
    logic o_mosi;
    logic o_sclk;
    logic o_cs_n;

    spi_shift_engine_if #(.DATA_W(DW), .DIV_W(DVW)) bus ();

    spi_shift_engine #(.DATA_W(DW), .DIV_W(DVW)) dut (
        .clk    (clk),
        .RST    (RST),
        .bus    (bus),
        .i_miso (i_miso),
        .o_mosi (o_mosi),
        .o_sclk (o_sclk),
        .o_cs_n (o_cs_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model / line monitor ----------------
    logic [DW-1:0] sl_word = '0;
    logic          sl_lsb  = 1'b0;
    logic          sl_cpha = 1'b0;
    bit            mon_q[$];
    int            mon_edges, mon_rises, mon_unstable, mon_done_cnt;
    int            mon_last_cyc, mon_hp_min, mon_hp_max;
    logic          prev_sclk, prev_cs_n, prev_mosi;

    function automatic logic sl_bit(input int i);
        return sl_lsb ? sl_word[i] : sl_word[DW-1-i];
    endfunction

    // Word the slave saw on MOSI, assembled in the transfer's bit order.
    function automatic logic [DW-1:0] seen_word(input logic lsb);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < mon_q.size() && i < DW; i++) begin
            if (lsb) w[i] = mon_q[i];
            else     w[DW-1-i] = mon_q[i];
        end
        return w;
    endfunction

    // o_done is registered on clock edge T + 1 + (2*DW+2)*H, counting the edge
    // that samples i_start as T; i.e. it is high in the cycle that ends at edge
    // T + 2 + (2*DW+2)*H.
    function automatic int exp_lat(input int div);
        return 1 + (2 * DW + 2) * (div + 1);
    endfunction

    initial begin
        i_miso = 1'b0;
        prev_sclk = 1'b0; prev_cs_n = 1'b1; prev_mosi = 1'b0;
        mon_edges = 0; mon_rises = 0; mon_unstable = 0; mon_done_cnt = 0;
        mon_last_cyc = 0; mon_hp_min = 0; mon_hp_max = 0;
        forever begin
            @(posedge clk); #1;
            if (bus.o_done === 1'b1) mon_done_cnt++;
            if (prev_cs_n === 1'b1 && o_cs_n === 1'b0) begin
                mon_q.delete();
                mon_edges = 0; mon_rises = 0; mon_unstable = 0;
                mon_hp_min = 1 << 30; mon_hp_max = 0; mon_last_cyc = cyc;
                if (!sl_cpha) i_miso = sl_bit(0);
            end else if (prev_cs_n === 1'b0 && o_sclk !== prev_sclk) begin
                mon_edges++;
                if (o_sclk === 1'b1) mon_rises++;
                if (mon_edges > 1) begin
                    if (cyc - mon_last_cyc < mon_hp_min) mon_hp_min = cyc - mon_last_cyc;
                    if (cyc - mon_last_cyc > mon_hp_max) mon_hp_max = cyc - mon_last_cyc;
                end
                mon_last_cyc = cyc;
                if (sl_cpha ? (mon_edges % 2 == 0) : (mon_edges % 2 == 1)) begin
                    mon_q.push_back(prev_mosi);
                    if (o_mosi !== prev_mosi) mon_unstable++;
                end
                if (!sl_cpha && (mon_edges % 2 == 0) && mon_edges < 2 * DW)
                    i_miso = sl_bit(mon_edges / 2);
                if (sl_cpha && (mon_edges % 2 == 1))
                    i_miso = sl_bit((mon_edges - 1) / 2);
            end
            prev_sclk = o_sclk; prev_cs_n = o_cs_n; prev_mosi = o_mosi;
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic launch(input logic [DW-1:0] tx, input logic [DW-1:0] rx,
                          input int div, input logic cpol, input logic cpha,
                          input logic lsb, output int t_start);
        @(negedge clk);
        bus.i_tx_data = tx; bus.i_clk_div = DVW'(div);
        bus.i_cpol = cpol; bus.i_cpha = cpha; bus.i_lsb_first = lsb;
        sl_word = rx; sl_lsb = lsb; sl_cpha = cpha;
        repeat (2) @(negedge clk);
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        t_start = cyc;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int t_done, output bit ok);
        ok = 1'b0; t_done = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (bus.o_done === 1'b1) begin
                t_done = cyc; ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", o_cs_n); end
        checks++; if (o_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", o_sclk); end
        checks++; if (o_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", o_mosi); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
        checks++; if (bus.o_rx_data !== '0) begin errors++; $display("FAIL reset_rx: got %h want 00", bus.o_rx_data); end
        @(negedge clk); RST = 1'b0;
    endtask

    task automatic test_mode0();
        int ts, td; bit ok;
        launch(8'hA5, 8'h3C, 1, 1'b0, 1'b0, 1'b0, ts);
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL m0_busy: got %b want 1", bus.o_busy); end
        wait_done(200, td, ok);
        checks++; if (!ok) begin errors++; $display("FAIL m0_timeout: got no o_done want o_done"); end
        checks++; if (td - ts !== exp_lat(1)) begin errors++; $display("FAIL m0_latency: got %0d want %0d", td - ts, exp_lat(1)); end
        checks++; if (bus.o_rx_data !== 8'h3C) begin errors++; $display("FAIL m0_rx: got %h want 3c", bus.o_rx_data); end
        checks++; if (seen_word(1'b0) !== 8'hA5 || mon_q.size() != DW) begin errors++; $display("FAIL m0_mosi: got %h (%0d bits) want a5", seen_word(1'b0), mon_q.size()); end
        checks++; if (mon_rises != DW) begin errors++; $display("FAIL m0_rises: got %0d want %0d", mon_rises, DW); end
        checks++; if (mon_unstable != 0) begin errors++; $display("FAIL m0_mosi_stable: got %0d changes want 0", mon_unstable); end
        checks++; if (o_cs_n !== 1'b1 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL m0_done_state: got cs_n=%b busy=%b want 1/0", o_cs_n, bus.o_busy); end
    endtask

    task automatic test_modes();
        logic [1:0] modes [3];
        int ts, td; bit ok;
        modes[0] = c_MODE1; modes[1] = c_MODE2; modes[2] = c_MODE3;
        for (int m = 0; m < 3; m++) begin
            @(negedge clk); bus.i_cpol = modes[m][1];
            repeat (2) @(posedge clk); #1;
            checks++; if (o_sclk !== modes[m][1]) begin errors++; $display("FAIL mode%0d_idle_sclk: got %b want %b", m + 1, o_sclk, modes[m][1]); end
            launch(8'h81, 8'h7E, 0, modes[m][1], modes[m][0], 1'b0, ts);
            wait_done(100, td, ok);
            checks++; if (!ok || td - ts !== exp_lat(0)) begin errors++; $display("FAIL mode%0d_latency: got %0d want %0d", m + 1, td - ts, exp_lat(0)); end
            checks++; if (bus.o_rx_data !== 8'h7E) begin errors++; $display("FAIL mode%0d_rx: got %h want 7e", m + 1, bus.o_rx_data); end
            checks++; if (seen_word(1'b0) !== 8'h81 || mon_unstable != 0) begin errors++; $display("FAIL mode%0d_mosi: got %h unstable=%0d want 81", m + 1, seen_word(1'b0), mon_unstable); end
            checks++; if (mon_edges != 2 * DW || o_sclk !== modes[m][1]) begin errors++; $display("FAIL mode%0d_edges: got %0d edges sclk=%b want %0d/%b", m + 1, mon_edges, o_sclk, 2 * DW, modes[m][1]); end
        end
    endtask

    task automatic test_lsb_first();
        int ts, td; bit ok;
        launch(8'h01, 8'h01, 1, 1'b0, 1'b0, 1'b1, ts);
        wait_done(200, td, ok);
        checks++; if (!ok || mon_q.size() == 0 || mon_q[0] !== 1'b1) begin errors++; $display("FAIL lsb_first_bit: got size %0d want first bit 1", mon_q.size()); end
        checks++; if (bus.o_rx_data !== 8'h01) begin errors++; $display("FAIL lsb_rx: got %h want 01", bus.o_rx_data); end
        checks++; if (seen_word(1'b1) !== 8'h01) begin errors++; $display("FAIL lsb_mosi: got %h want 01", seen_word(1'b1)); end
    endtask

    task automatic test_random();
        int ts, td, div; bit ok;
        logic [DW-1:0] tx, rx; logic cpol, cpha, lsb;
        for (int n = 0; n < 8; n++) begin
            tx = DW'($urandom); rx = DW'($urandom); div = $urandom_range(0, 3);
            cpol = 1'($urandom); cpha = 1'($urandom); lsb = 1'($urandom);
            launch(tx, rx, div, cpol, cpha, lsb, ts);
            wait_done(400, td, ok);
            checks++; if (!ok || td - ts !== exp_lat(div)) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, td - ts, exp_lat(div)); end
            checks++; if (bus.o_rx_data !== rx) begin errors++; $display("FAIL rnd%0d_rx: got %h want %h", n, bus.o_rx_data, rx); end
            checks++; if (seen_word(lsb) !== tx || mon_unstable != 0) begin errors++; $display("FAIL rnd%0d_mosi: got %h want %h", n, seen_word(lsb), tx); end
        end
    endtask

    task automatic test_midchange();
        int ts, td, d0; bit ok;
        launch(8'hC6, 8'h5A, 1, 1'b0, 1'b0, 1'b0, ts);
        d0 = mon_done_cnt;
        repeat (4) @(negedge clk);
        bus.i_start = 1'b1; bus.i_tx_data = 8'h39; bus.i_clk_div = 8'd0;
        bus.i_cpha = 1'b1; bus.i_lsb_first = 1'b1; bus.i_cpol = 1'b1;
        repeat (3) @(negedge clk);
        bus.i_start = 1'b0;
        repeat (10) @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0; bus.i_cpol = 1'b0;
        wait_done(200, td, ok);
        checks++; if (!ok || td - ts !== exp_lat(1)) begin errors++; $display("FAIL mid_latency: got %0d want %0d", td - ts, exp_lat(1)); end
        checks++; if (bus.o_rx_data !== 8'h5A) begin errors++; $display("FAIL mid_rx: got %h want 5a", bus.o_rx_data); end
        checks++; if (seen_word(1'b0) !== 8'hC6) begin errors++; $display("FAIL mid_mosi: got %h want c6", seen_word(1'b0)); end
        repeat (40) @(posedge clk); #1;
        checks++; if (mon_done_cnt - d0 != 1 || o_cs_n !== 1'b1) begin errors++; $display("FAIL mid_single_done: got %0d dones cs_n=%b want 1/1", mon_done_cnt - d0, o_cs_n); end
    endtask

    task automatic test_back_to_back();
        int ts, td; bit ok;
        launch(8'h3A, 8'hE1, 0, 1'b0, 1'b0, 1'b0, ts);
        wait_done(100, td, ok);
        checks++; if (!ok || o_cs_n !== 1'b1) begin errors++; $display("FAIL b2b_done_cs: got ok=%b cs_n=%b want 1/1", ok, o_cs_n); end
        // Start held from the DONE cycle: ignored there, accepted one cycle later.
        @(negedge clk);
        bus.i_tx_data = 8'h96; bus.i_clk_div = 8'd0; bus.i_lsb_first = 1'b0;
        sl_word = 8'h2D; sl_lsb = 1'b0; sl_cpha = 1'b0;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_cs_n !== 1'b1 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL b2b_gap2: got cs_n=%b busy=%b want 1/0", o_cs_n, bus.o_busy); end
        @(posedge clk); #1;
        ts = cyc;
        checks++; if (o_cs_n !== 1'b0 || bus.o_busy !== 1'b1) begin errors++; $display("FAIL b2b_start: got cs_n=%b busy=%b want 0/1", o_cs_n, bus.o_busy); end
        @(negedge clk); bus.i_start = 1'b0;
        wait_done(100, td, ok);
        checks++; if (!ok || td - ts !== exp_lat(0)) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", td - ts, exp_lat(0)); end
        checks++; if (bus.o_rx_data !== 8'h2D || seen_word(1'b0) !== 8'h96) begin errors++; $display("FAIL b2b_data: got rx %h mosi %h want 2d/96", bus.o_rx_data, seen_word(1'b0)); end
    endtask

    task automatic test_reset_mid();
        int ts, td, d0; bit ok;
        launch(8'hF0, 8'h0F, 1, 1'b0, 1'b0, 1'b0, ts);
        for (int i = 0; i < 100 && mon_edges < 3; i++) @(posedge clk);
        checks++; if (mon_edges < 3) begin errors++; $display("FAIL rst_mid_reach_shift: got %0d edges want >=3", mon_edges); end
        @(negedge clk); RST = 1'b1;
        d0 = mon_done_cnt;
        @(posedge clk); #1;
        checks++; if (o_cs_n !== 1'b1 || o_sclk !== 1'b0 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_lines: got cs_n=%b sclk=%b busy=%b want 1/0/0", o_cs_n, o_sclk, bus.o_busy); end
        checks++; if (bus.o_rx_data !== '0 || bus.o_done !== 1'b0) begin errors++; $display("FAIL rst_mid_rx: got rx=%h done=%b want 00/0", bus.o_rx_data, bus.o_done); end
        @(negedge clk); RST = 1'b0;
        repeat (60) @(posedge clk); #1;
        checks++; if (mon_done_cnt != d0) begin errors++; $display("FAIL rst_mid_no_done: got %0d dones want 0", mon_done_cnt - d0); end
        launch(8'h55, 8'hAA, 1, 1'b0, 1'b0, 1'b0, ts);
        wait_done(200, td, ok);
        checks++; if (!ok || bus.o_rx_data !== 8'hAA || seen_word(1'b0) !== 8'h55) begin errors++; $display("FAIL rst_mid_after: got rx %h mosi %h want aa/55", bus.o_rx_data, seen_word(1'b0)); end
    endtask

    task automatic test_slow();
        int ts, td; bit ok;
        launch(8'h6B, 8'hD4, 255, 1'b0, 1'b0, 1'b0, ts);
        wait_done(6000, td, ok);
        checks++; if (!ok || td - ts !== exp_lat(255)) begin errors++; $display("FAIL slow_latency: got %0d want %0d", td - ts, exp_lat(255)); end
        checks++; if (mon_hp_min != 256 || mon_hp_max != 256) begin errors++; $display("FAIL slow_half_period: got %0d..%0d want 256", mon_hp_min, mon_hp_max); end
        checks++; if (bus.o_rx_data !== 8'hD4) begin errors++; $display("FAIL slow_rx: got %h want d4", bus.o_rx_data); end
    endtask

    initial begin
        RST = 1'b1;
        bus.i_start = 1'b0; bus.i_tx_data = '0; bus.i_clk_div = '0;
        bus.i_cpol = 1'b0; bus.i_cpha = 1'b0; bus.i_lsb_first = 1'b0;
        test_reset();
        test_mode0();
        test_modes();
        test_lsb_first();
        test_random();
        test_midchange();
        test_back_to_back();
        test_reset_mid();
        test_slow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spi_shift_engine
`default_nettype wire

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- SPI master serializer/deserializer. Sits directly downstream of spi_controller inside the AXI-to-SPI bridge.
- Takes one word plus mode/divider settings from the controller, drives o_sclk, o_mosi and o_cs_n, and samples i_miso.
- Returns the received word with a one-cycle done pulse. The controller uses that pulse to update its status register and raise the IRQ.

Parameters:
- DATA_W, 8: bits per transfer, 2..32.
- DIV_W, 8: width of the clock-divider setting.

Ports:
- clk  in  1  system clock (FCLK_CLK0 at bridge level).
- RST  in  1  synchronous, active-high reset.
- i_start  in  1  request a transfer; accepted only while idle.
- i_tx_data  in  DATA_W  word to transmit.
- i_clk_div  in  DIV_W  half-period of o_sclk minus one, in clk cycles.
- i_cpol  in  1  SPI clock polarity.
- i_cpha  in  1  SPI clock phase.
- i_lsb_first  in  1  1 = shift LSB first.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle pulse at end of transfer.
- o_rx_data  out  DATA_W  last received word; held until the next o_done.
- i_miso  in  1  serial data in.
- o_mosi  out  1  serial data out.
- o_sclk  out  1  SPI clock.
- o_cs_n  out  1  active-low chip select.

Behaviour:
- Reset (synchronous, RST=1 at a clk edge) overrides everything, including mid-transfer: state=IDLE, o_busy=0, o_done=0, o_rx_data=0, o_mosi=0, o_sclk=0, o_cs_n=1, shift registers and counters cleared. No o_done is generated for the aborted transfer.
- All outputs are registered.
- H = i_clk_div+1 clk cycles (half-period). i_clk_div=0 gives o_sclk = clk/2.
- States:
  - IDLE: o_sclk follows registered i_cpol each cycle; o_cs_n=1. On i_start, latch i_tx_data, i_clk_div, i_cpol, i_cpha, i_lsb_first → LEAD. Config inputs are ignored after the latch.
  - LEAD: o_cs_n=0, o_mosi = first bit (MSB, or LSB if i_lsb_first); lasts H cycles → SHIFT.
  - SHIFT: 2*DATA_W half-periods; o_sclk toggles at the end of each.
    - Leading edge = odd edge count, trailing edge = even edge count.
    - CPHA=0: sample i_miso on the leading edge; drive the next bit on the trailing edge (no drive after the last bit).
    - CPHA=1: drive on the leading edge (first bit already presented in LEAD and re-driven; harmless); sample on the trailing edge.
    - After edge 2*DATA_W, o_sclk is back at CPOL → TRAIL.
  - TRAIL: o_cs_n=0 for H cycles → DONE.
  - DONE: one cycle. o_cs_n=1, o_done=1, o_rx_data updated in this same cycle, o_busy=0 → IDLE.
- o_busy=1 from the cycle after start acceptance through the last TRAIL cycle.
- Latency: start sampled at edge T → o_done high in cycle T+2+(2*DATA_W+2)*H.
- i_start while o_busy=1 or in DONE: ignored, no queuing. A start in the first IDLE cycle after DONE is accepted, giving a minimum idle gap of 2 cycles with o_cs_n=1.
- Received bits assemble in the same order as transmitted: i_lsb_first=1 puts the first sampled bit in bit 0.
- The divider counter reloads from the latched i_clk_div at every half-period boundary. No wrap beyond 2^DIV_W cycles.

Decomposition:
- spi_pkg holds:
  - state enum (IDLE, LEAD, SHIFT, TRAIL, DONE);
  - mode constants: MODE0..MODE3 as {cpol,cpha};
  - default DATA_W and DIV_W.
- One natural sub-module: spi_half_period_timer.
  - Loadable down-counter of DIV_W bits with enable.
  - Emits a one-cycle tick every H cycles while enabled.
  - Restarts cleanly on load.

Test Plan:
- Mode 0, DATA_W=8, div=1, MSB-first, tx=0xA5, slave model returns 0x3C. Required:
  - o_mosi bits 1,0,1,0,0,1,0,1 stable at each rising o_sclk;
  - 8 rising edges;
  - o_rx_data=0x3C;
  - o_done exactly at T+38.
- Modes 1/2/3 with tx=0x81, rx=0x7E, div=0. Required: sample/drive edges match CPHA; idle and final o_sclk level = CPOL; o_rx_data=0x7E in all modes.
- LSB-first, tx=0x01, rx stream 1,0,0,0,0,0,0,0. Required: o_mosi first bit=1; o_rx_data=0x01.
- i_start pulsed mid-transfer and config inputs changed mid-transfer. Required: transfer unaffected, single o_done, no second transfer. Start in the cycle after DONE begins a new transfer with o_cs_n high for exactly 2 cycles.
- RST=1 during SHIFT. Required, next cycle: o_cs_n=1, o_sclk=0, o_busy=0, o_rx_data=0, no o_done. A subsequent transfer (tx=0x55, rx=0xAA) completes correctly.
- div=255, DATA_W=8. Required: o_sclk half-period = 256 cycles; o_done at T+2+18*256.
